// File: rtl/toy_mem_responder_if.sv
// Signal bundle between a core and toy_mem_responder.
// The master modport issues fetch/data requests; the slave modport answers them.
interface toy_mem_responder_if;
   // dmem handshake: valid only, no ready. A request is accepted in every cycle
   // where io_dmem_req_valid=1, and exactly one response (valid/data/err) follows
   // a fixed latency later. imem has no valid; its address is sampled every cycle.
   logic [31:0] io_imem_req_bits_addr;
   logic        io_imem_resp_valid;
   logic [31:0] io_imem_resp_bits_data;
   logic        io_dmem_req_valid;
   logic [31:0] io_dmem_req_bits_addr;
   logic [31:0] io_dmem_req_bits_data;
   logic        io_dmem_req_bits_fcn;
   logic [2:0]  io_dmem_req_bits_typ;
   logic        io_dmem_resp_valid;
   logic [31:0] io_dmem_resp_bits_data;
   logic        io_dmem_resp_bits_err;

   modport master (
      output io_imem_req_bits_addr,
      input  io_imem_resp_valid, io_imem_resp_bits_data,
      output io_dmem_req_valid, io_dmem_req_bits_addr, io_dmem_req_bits_data,
      output io_dmem_req_bits_fcn, io_dmem_req_bits_typ,
      input  io_dmem_resp_valid, io_dmem_resp_bits_data, io_dmem_resp_bits_err
   );

   modport slave (
      input  io_imem_req_bits_addr,
      output io_imem_resp_valid, io_imem_resp_bits_data,
      input  io_dmem_req_valid, io_dmem_req_bits_addr, io_dmem_req_bits_data,
      input  io_dmem_req_bits_fcn, io_dmem_req_bits_typ,
      output io_dmem_resp_valid, io_dmem_resp_bits_data, io_dmem_resp_bits_err
   );
endinterface

// File: rtl/toy_mem_responder.sv
// Single-array instruction/data memory model with fixed-latency dmem responses.
// Optional macro TOY_MEM_MISALIGN_CHECK_EN: misaligned H/W accesses report err instead of being aligned.
module toy_mem_responder #(
   parameter int DEPTH_WORDS = 4096,
   parameter int DMEM_LAT    = 1
) (
   input  logic                clock,
   input  logic                reset,
   toy_mem_responder_if.slave  io
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);

   logic [31:0]       mem_q [DEPTH_WORDS];
   logic [31:0]       imem_data_q;
   logic              imem_valid_q;
   logic [IDX_W-1:0]  imem_idx;
   logic [IDX_W-1:0]  dmem_idx;
   logic [2:0]        typ;
   logic [1:0]        off;
   logic              is_b, is_h, is_w, legal, misal, err;
   logic [31:0]       rd_word, ld_data, st_data;
   logic [7:0]        rd_byte;
   logic [15:0]       rd_half;
   logic [3:0]        st_mask;
   logic              we;
   logic              resp_valid_d, resp_err_d;
   logic [31:0]       resp_data_d;
   logic [DMEM_LAT-1:0] pv_q, pe_q;
   logic [31:0]       pd_q [DMEM_LAT];
   logic              unused_addr_bits;

   assign imem_idx = io.io_imem_req_bits_addr[IDX_W+1:2];
   assign dmem_idx = io.io_dmem_req_bits_addr[IDX_W+1:2];
   assign typ      = io.io_dmem_req_bits_typ;
   assign unused_addr_bits = ^{io.io_imem_req_bits_addr[31:IDX_W+2], io.io_imem_req_bits_addr[1:0],
                               io.io_dmem_req_bits_addr[31:IDX_W+2]};

   always_comb begin
      is_b  = (typ == 3'd1) || (typ == 3'd5);
      is_h  = (typ == 3'd2) || (typ == 3'd6);
      is_w  = (typ == 3'd3);
      legal = is_b || is_h || is_w;
      off   = io.io_dmem_req_bits_addr[1:0];
`ifdef TOY_MEM_MISALIGN_CHECK_EN
      misal = (is_h && off[0]) || (is_w && (off != 2'd0));
`else
      misal = 1'b0;
      if (is_h) off[0] = 1'b0;
      if (is_w) off = 2'd0;
`endif
      err     = !legal || misal;
      rd_word = mem_q[dmem_idx];
      rd_byte = rd_word[{off, 3'b000} +: 8];
      rd_half = rd_word[{off[1], 4'b0000} +: 16];
      ld_data = rd_word;
      // typ[2] marks the unsigned variants (BU/HU).
      if (is_b)      ld_data = typ[2] ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      else if (is_h) ld_data = typ[2] ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      st_data = io.io_dmem_req_bits_data;
      st_mask = 4'b1111;
      if (is_b) begin
         st_data = {4{io.io_dmem_req_bits_data[7:0]}};
         st_mask = 4'b0001 << off;
      end else if (is_h) begin
         st_data = {2{io.io_dmem_req_bits_data[15:0]}};
         st_mask = off[1] ? 4'b1100 : 4'b0011;
      end
      we           = io.io_dmem_req_valid && io.io_dmem_req_bits_fcn && !err && !reset;
      resp_valid_d = io.io_dmem_req_valid;
      resp_err_d   = err;
      resp_data_d  = (!io.io_dmem_req_bits_fcn && !err) ? ld_data : 32'd0;
   end

   // Array is never reset; the imem read uses pre-store contents (read-before-write).
   always_ff @(posedge clock) begin
      imem_data_q <= mem_q[imem_idx];
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (st_mask[b]) mem_q[dmem_idx][8*b +: 8] <= st_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         imem_valid_q <= 1'b0;
         pv_q         <= '0;
         pe_q         <= '0;
         for (int i = 0; i < DMEM_LAT; i++) pd_q[i] <= 32'd0;
      end else begin
         imem_valid_q <= 1'b1;
         pv_q[0]      <= resp_valid_d;
         pe_q[0]      <= resp_err_d;
         pd_q[0]      <= resp_data_d;
         for (int i = 1; i < DMEM_LAT; i++) begin
            pv_q[i] <= pv_q[i-1];
            pe_q[i] <= pe_q[i-1];
            pd_q[i] <= pd_q[i-1];
         end
      end
   end

   // Outputs are also gated by reset so they read zero from the very first reset cycle.
   assign io.io_imem_resp_valid     = imem_valid_q & ~reset;
   assign io.io_imem_resp_bits_data = imem_data_q;
   assign io.io_dmem_resp_valid     = pv_q[DMEM_LAT-1] & ~reset;
   assign io.io_dmem_resp_bits_err  = pe_q[DMEM_LAT-1] & ~reset;
   assign io.io_dmem_resp_bits_data = reset ? 32'd0 : pd_q[DMEM_LAT-1];
endmodule

// File: tb/tb_toy_mem_responder.sv
// Directed + randomized bench for toy_mem_responder with an expected-response queue.
// Build with or without TOY_MEM_MISALIGN_CHECK_EN; expectations follow the same macro.
module tb_toy_mem_responder;
   localparam int DEPTH = 256;
   localparam int LAT   = 2;
   localparam int IDX   = $clog2(DEPTH);

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   logic [32:0] exp_q[$];
   int          exp_cyc_q[$];
   logic [31:0] model [DEPTH];
   logic [32:0] mon_e;
   int          mon_c;

   toy_mem_responder_if mif ();

   toy_mem_responder #(.DEPTH_WORDS(DEPTH), .DMEM_LAT(LAT)) dut (
      .clock(clk),
      .reset(rst),
      .io   (mif)
   );

   // ---------------- clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- checking
   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp_v);
      n_chk++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
   endtask

   // Scoreboard monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_dmem_valid", {32'd0, mif.io_dmem_resp_valid}, 33'd0);
         chk("rst_dmem_data", {1'b0, mif.io_dmem_resp_bits_data}, 33'd0);
         chk("rst_dmem_err", {32'd0, mif.io_dmem_resp_bits_err}, 33'd0);
         chk("rst_imem_valid", {32'd0, mif.io_imem_resp_valid}, 33'd0);
      end else if (mif.io_dmem_resp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", {1'b0, mif.io_dmem_resp_bits_data}, 33'h1_0000_0000);
         end else begin
            mon_e = exp_q.pop_front();
            mon_c = exp_cyc_q.pop_front();
            chk("resp_err_data", {mif.io_dmem_resp_bits_err, mif.io_dmem_resp_bits_data}, mon_e);
            chk("resp_cycle", 33'(cyc), 33'(mon_c));
         end
      end
   end

   // ---------------- drivers
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic dmem_req(input logic fcn, input logic [2:0] typ, input logic [31:0] addr,
                           input logic [31:0] data, input logic exp_err, input logic [31:0] exp_data);
      mif.io_dmem_req_valid     = 1'b1;
      mif.io_dmem_req_bits_fcn  = fcn;
      mif.io_dmem_req_bits_typ  = typ;
      mif.io_dmem_req_bits_addr = addr;
      mif.io_dmem_req_bits_data = data;
      exp_q.push_back({exp_err, exp_data});
      exp_cyc_q.push_back(cyc + LAT);
      step(1);
      mif.io_dmem_req_valid = 1'b0;
   endtask

   task automatic store_model(input logic [2:0] typ, input logic [31:0] addr, input logic [31:0] data);
      int          idx;
      int          o;
      logic [31:0] w;
      idx = int'(addr[IDX+1:2]);
      o   = int'(addr[1:0]);
      w   = model[idx];
      case (typ)
         3'd1:    w[8*o +: 8] = data[7:0];
         3'd2:    w[16*(o/2) +: 16] = data[15:0];
         default: w = data;
      endcase
      model[idx] = w;
      dmem_req(1'b1, typ, addr, data, 1'b0, 32'd0);
   endtask

   task automatic load_model(input logic [2:0] typ, input logic [31:0] addr);
      int          o;
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      o = int'(addr[1:0]);
      w = model[int'(addr[IDX+1:2])];
      b = w[8*o +: 8];
      h = w[16*(o/2) +: 16];
      case (typ)
         3'd1:    r = {{24{b[7]}}, b};
         3'd5:    r = {24'd0, b};
         3'd2:    r = {{16{h[15]}}, h};
         3'd6:    r = {16'd0, h};
         default: r = w;
      endcase
      dmem_req(1'b0, typ, addr, 32'd0, 1'b0, r);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1);
      chk(tag, 33'(exp_q.size()), 33'd0);
   endtask

   // ---------------- stimulus
   initial begin
      logic [2:0]  typs [5];
      logic [2:0]  t;
      logic [31:0] a;
      typs = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
      mif.io_imem_req_bits_addr = 32'd0;
      mif.io_dmem_req_valid     = 1'b0;
      mif.io_dmem_req_bits_addr = 32'd0;
      mif.io_dmem_req_bits_data = 32'd0;
      mif.io_dmem_req_bits_fcn  = 1'b0;
      mif.io_dmem_req_bits_typ  = 3'd3;

      // Reset, then imem valid rises one cycle after the first non-reset cycle.
      step(3);
      rst = 1'b0;
      @(negedge clk);
      chk("imem_valid_first", {32'd0, mif.io_imem_resp_valid}, 33'd0);
      @(negedge clk);
      chk("imem_valid_after", {32'd0, mif.io_imem_resp_valid}, 33'd1);
      step(1);

      // Word store/load, byte store and extended loads, back-to-back.
      dmem_req(1'b1, 3'd3, 32'h100, 32'hDEADBEEF, 1'b0, 32'd0);
      dmem_req(1'b0, 3'd3, 32'h100, 32'd0, 1'b0, 32'hDEADBEEF);
      dmem_req(1'b1, 3'd1, 32'h103, 32'h00000080, 1'b0, 32'd0);
      dmem_req(1'b0, 3'd1, 32'h103, 32'd0, 1'b0, 32'hFFFFFF80);
      dmem_req(1'b0, 3'd5, 32'h103, 32'd0, 1'b0, 32'h00000080);
      dmem_req(1'b0, 3'd3, 32'h100, 32'd0, 1'b0, 32'h80ADBEEF);

      // Same-cycle imem read and dmem store to one word: old data first, new data next.
      mif.io_imem_req_bits_addr = 32'h100;
      dmem_req(1'b1, 3'd3, 32'h100, 32'h12345678, 1'b0, 32'd0);
      @(negedge clk);
      chk("imem_read_before_write", {1'b0, mif.io_imem_resp_bits_data}, {1'b0, 32'h80ADBEEF});
      step(1);
      @(negedge clk);
      chk("imem_read_new", {1'b0, mif.io_imem_resp_bits_data}, {1'b0, 32'h12345678});
      step(1);

      // Halfword accesses, aligned and misaligned.
      dmem_req(1'b0, 3'd6, 32'h102, 32'd0, 1'b0, 32'h00001234);
      dmem_req(1'b1, 3'd2, 32'h102, 32'h0000BEEF, 1'b0, 32'd0);
      dmem_req(1'b0, 3'd2, 32'h102, 32'd0, 1'b0, 32'hFFFFBEEF);
      dmem_req(1'b0, 3'd6, 32'h102, 32'd0, 1'b0, 32'h0000BEEF);
`ifdef TOY_MEM_MISALIGN_CHECK_EN
      dmem_req(1'b0, 3'd2, 32'h101, 32'd0, 1'b1, 32'd0);
      dmem_req(1'b0, 3'd3, 32'h103, 32'd0, 1'b1, 32'd0);
      dmem_req(1'b1, 3'd3, 32'h102, 32'hAAAAAAAA, 1'b1, 32'd0);
      dmem_req(1'b0, 3'd3, 32'h100, 32'd0, 1'b0, 32'hBEEF5678);
`else
      dmem_req(1'b0, 3'd2, 32'h101, 32'd0, 1'b0, 32'h00005678);
      dmem_req(1'b0, 3'd3, 32'h103, 32'd0, 1'b0, 32'hBEEF5678);
      dmem_req(1'b1, 3'd3, 32'h102, 32'hAAAAAAAA, 1'b0, 32'd0);
      dmem_req(1'b0, 3'd3, 32'h100, 32'd0, 1'b0, 32'hAAAAAAAA);
`endif
      drain("drain_directed");

      // Address aliasing and illegal typ codes.
      dmem_req(1'b1, 3'd3, DEPTH * 4, 32'hCAFEF00D, 1'b0, 32'd0);
      dmem_req(1'b0, 3'd3, 32'h0, 32'd0, 1'b0, 32'hCAFEF00D);
      dmem_req(1'b1, 3'd7, 32'h0, 32'h11111111, 1'b1, 32'd0);
      dmem_req(1'b0, 3'd4, 32'h0, 32'd0, 1'b1, 32'd0);
      dmem_req(1'b1, 3'd0, 32'h0, 32'h22222222, 1'b1, 32'd0);
      dmem_req(1'b0, 3'd3, 32'h0, 32'd0, 1'b0, 32'hCAFEF00D);
      mif.io_imem_req_bits_addr = DEPTH * 8;
      step(1);
      @(negedge clk);
      chk("imem_alias", {1'b0, mif.io_imem_resp_bits_data}, {1'b0, 32'hCAFEF00D});
      step(1);
      drain("drain_alias");

      // Four consecutive loads; reset lands in the second response cycle.
      for (int i = 0; i < 4; i++) begin
         mif.io_dmem_req_valid     = 1'b1;
         mif.io_dmem_req_bits_fcn  = 1'b0;
         mif.io_dmem_req_bits_typ  = 3'd3;
         mif.io_dmem_req_bits_addr = 32'h0;
         if (i == 0) begin
            exp_q.push_back({1'b0, 32'hCAFEF00D});
            exp_cyc_q.push_back(cyc + LAT);
         end
         if (i == 3) rst = 1'b1;
         step(1);
      end
      // A store issued while reset is held must not commit.
      mif.io_dmem_req_bits_fcn  = 1'b1;
      mif.io_dmem_req_bits_data = 32'hBAD0BAD0;
      step(2);
      mif.io_dmem_req_valid = 1'b0;
      rst = 1'b0;
      step(6);
      chk("reset_flush_queue", 33'(exp_q.size()), 33'd0);
      dmem_req(1'b0, 3'd3, 32'h0, 32'd0, 1'b0, 32'hCAFEF00D);
      drain("drain_reset");

      // Randomized back-to-back traffic over a small region, checked against the model.
      for (int i = 0; i < 8; i++) store_model(3'd3, 32'h200 + 32'(i * 4), $urandom);
      for (int i = 0; i < 40; i++) begin
         a = 32'h200 + 32'($urandom_range(0, 7) * 4);
         if ($urandom_range(0, 1) == 1) begin
            t = 3'($urandom_range(1, 3));
            if (t == 3'd1) a = a + 32'($urandom_range(0, 3));
            if (t == 3'd2) a = a + 32'($urandom_range(0, 1) * 2);
            store_model(t, a, $urandom);
         end else begin
            t = typs[$urandom_range(0, 4)];
            if (t == 3'd1 || t == 3'd5) a = a + 32'($urandom_range(0, 3));
            if (t == 3'd2 || t == 3'd6) a = a + 32'($urandom_range(0, 1) * 2);
            load_model(t, a);
         end
      end
      drain("drain_random");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/toy_mem_responder.md
TOY_MEM_RESPONDER -- requirements
Module: toy_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096: number of 32-bit words in the backing array, power of two, 256..65536.
REQ-002 Parameter DMEM_LAT, default 1: dmem response latency in cycles, range 1..4.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 io_imem_req_bits_addr  input  32  instruction fetch byte address, sampled every cycle (no valid).
REQ-006 io_imem_resp_valid  output  1  fetch data valid.
REQ-007 io_imem_resp_bits_data  output  32  fetched word.
REQ-008 io_dmem_req_valid  input  1  data request present.
REQ-009 io_dmem_req_bits_addr  input  32  data byte address.
REQ-010 io_dmem_req_bits_data  input  32  store data, right-aligned.
REQ-011 io_dmem_req_bits_fcn  input  1  0 = load, 1 = store.
REQ-012 io_dmem_req_bits_typ  input  3  1=B, 2=H, 3=W, 5=BU, 6=HU; other codes are illegal.
REQ-013 io_dmem_resp_valid  output  1  load data or store acknowledge.
REQ-014 io_dmem_resp_bits_data  output  32  load result, extended per typ; 0 for stores.
REQ-015 io_dmem_resp_bits_err  output  1  qualifies resp_valid: access was misaligned or illegal.

Function
REQ-016 Word index = addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so accesses alias (wrap) modulo array size.
REQ-017 imem: the word at the index sampled in cycle N drives io_imem_resp_bits_data in cycle N+1; io_imem_resp_valid is 1 in every cycle after the first non-reset cycle.
REQ-018 dmem accepts one request per cycle whenever io_dmem_req_valid=1; there is no backpressure and no busy state.
REQ-019 Load data is read in the acceptance cycle and delivered exactly DMEM_LAT cycles later, through a DMEM_LAT-deep valid/data/err shift pipeline.
REQ-020 Load extraction: B/BU select the byte at addr[1:0]; H/HU select the halfword at addr[1]; B/H sign-extend; BU/HU zero-extend; W returns the full word.
REQ-021 Store commits at the end of the acceptance cycle using a byte mask: B = 1 byte at addr[1:0] taking data[7:0]; H = 2 bytes at addr[1] taking data[15:0]; W = all 4 bytes.
REQ-022 A store returns a response DMEM_LAT cycles after acceptance, with data 0.
REQ-023 Same-cycle imem read and dmem store to the same word: imem returns the old contents (read-before-write).
REQ-024 A load in cycle N+1 to a word stored in cycle N returns the new data.
REQ-025 An illegal typ code produces an err=1 response, data 0, and leaves memory unmodified.
REQ-026 Back-to-back requests produce back-to-back responses in order, with no bubbles.

Reset
REQ-027 While reset=1: io_imem_resp_valid=0, io_dmem_resp_valid=0, io_dmem_resp_bits_data=0, io_dmem_resp_bits_err=0, all pipeline valid bits are cleared, and no store commits.
REQ-028 Reset during in-flight requests discards them; they produce no response after reset deasserts.
REQ-029 Array contents are not reset; they hold their values across reset.

Configuration
REQ-030 Macro TOY_MEM_MISALIGN_CHECK_EN defined: H/HU with addr[0]=1, or W with addr[1:0]!=0, returns err=1 and data 0; a misaligned store is suppressed.
REQ-031 TOY_MEM_MISALIGN_CHECK_EN undefined: misaligned addresses are forced to natural alignment (H clears addr[0], W clears addr[1:0]), the access proceeds normally, and err is asserted only for illegal typ.

Verification
REQ-032 Store W 0xDEADBEEF to 0x100, then load W 0x100 -> response 0xDEADBEEF, err=0, DMEM_LAT cycles after the load.
REQ-033 Store B 0x80 to 0x103, then load B 0x103 -> 0xFFFFFF80; load BU 0x103 -> 0x00000080; load W 0x100 -> 0x80ADBEEF.
REQ-034 Same-cycle imem read of 0x100 and store W 0x12345678 to 0x100 -> imem returns old word 0x80ADBEEF; imem read the next cycle returns 0x12345678.
REQ-035 Load H 0x101 -> with TOY_MEM_MISALIGN_CHECK_EN: err=1, data 0; without it: returns the sign-extended halfword at 0x100.
REQ-036 Issue loads on 4 consecutive cycles, assert reset during the second response cycle -> no resp_valid during reset or afterwards; memory contents are unchanged.
REQ-037 Store W to DEPTH_WORDS*4, then read 0x0 -> reads alias and return the stored value; typ=7 request -> err=1, memory unchanged.
